// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core.
// Steps each instruction through fetch, decode, execute, memory and writeback,
// drives the datapath control lines from the current state, stalls on the
// memory ready handshake and counts retired instructions.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             alu_out_en,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Supported major opcodes
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALUOp codes seen by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic              retire_c;

    // State and retire counter registers; reset forces IDLE so every output drops at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and control decode from the current state
    always_comb begin
        state_d       = state_q;
        retire_c      = 1'b0;
        alu_op        = ALUOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_out_en    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // IR load and PC+4 happen only on the cycle the read completes
                mem_read = 1'b1;
                i_or_d   = 1'b0;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_R_TYPE: state_d = S_EXEC_R;
                    OP_I_TYPE: state_d = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = S_BRANCH;
                    default:   state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                alu_out_en = 1'b1;
                state_d    = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                alu_out_en = 1'b1;
                state_d    = S_WB_ALU;
            end

            S_MEM_ADDR: begin
                // Effective address rs1 + imm; opcode still valid in the IR
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_ADD;
                alu_out_en = 1'b1;
                state_d    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_c = 1'b1;
                end
            end

            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b0;
                state_d    = S_FETCH;
                retire_c   = 1'b1;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire_c   = 1'b1;
            end

            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_RS2;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                state_d       = S_FETCH;
                retire_c      = 1'b1;
            end

            S_TRAP: begin
                // Parked until reset; nothing retires from here
                illegal = 1'b1;
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Retired-instruction count, free-running modulo 2^CNT_W
    always_comb begin
        retired_d = retired_q;
        if (retire_c) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected state,
// control vector and retire count are queued per instruction and compared
// cycle by cycle as the FSM runs.
module tb_multicycle_control;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_EXEC_R   = 4'd3;
    localparam logic [3:0] ST_EXEC_I   = 4'd4;
    localparam logic [3:0] ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_MEM_WR   = 4'd7;
    localparam logic [3:0] ST_WB_ALU   = 4'd8;
    localparam logic [3:0] ST_WB_MEM   = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_out_en;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;
    logic [3:0] retired;

    multicycle_control #(.CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_out_en    (alu_out_en),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .state         (state),
        .retired       (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic [6:0]  op;
        logic [15:0] ctrl;
        logic [3:0]  ret;
    } cyc_t;

    cyc_t       sb[$];
    int         n_vec;
    int         n_err;
    logic [3:0] exp_ret;
    logic [6:0] cur_op;

    // Packed view of every control output, in a fixed order
    wire [15:0] act_ctrl = {alu_op, alu_src_a, alu_src_b, alu_out_en, mem_read, mem_write,
                            i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                            reg_write, mem_to_reg, illegal};

    // Reference control table per state (same field order as act_ctrl)
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic [1:0] aop; logic sa; logic [1:0] sb_sel; logic aoe;
        logic mr; logic mw; logic iod; logic irw; logic pw; logic pwc; logic ps;
        logic rw; logic m2r; logic ill;
        aop = 2'b00; sa = 1'b0; sb_sel = 2'b00; aoe = 1'b0; mr = 1'b0; mw = 1'b0;
        iod = 1'b0; irw = 1'b0; pw = 1'b0; pwc = 1'b0; ps = 1'b0; rw = 1'b0;
        m2r = 1'b0; ill = 1'b0;
        case (st)
            ST_FETCH:    begin mr = 1'b1; irw = rdy; pw = rdy; end
            ST_EXEC_R:   begin sa = 1'b1; sb_sel = 2'b00; aop = 2'b10; aoe = 1'b1; end
            ST_EXEC_I:   begin sa = 1'b1; sb_sel = 2'b10; aop = 2'b00; aoe = 1'b1; end
            ST_MEM_ADDR: begin sa = 1'b1; sb_sel = 2'b10; aop = 2'b00; aoe = 1'b1; end
            ST_MEM_RD:   begin mr = 1'b1; iod = 1'b1; end
            ST_MEM_WR:   begin mw = 1'b1; iod = 1'b1; end
            ST_WB_ALU:   begin rw = 1'b1; end
            ST_WB_MEM:   begin rw = 1'b1; m2r = 1'b1; end
            ST_BRANCH:   begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 1'b1; end
            ST_TRAP:     begin ill = 1'b1; end
            default:     ;
        endcase
        return {aop, sa, sb_sel, aoe, mr, mw, iod, irw, pw, pwc, ps, rw, m2r, ill};
    endfunction

    // Queue one expected cycle; inputs the FSM should ignore are randomised
    task automatic push_cyc(input logic [3:0] st, input logic rdy);
        cyc_t e;
        e.st  = st;
        e.rdy = (st == ST_FETCH || st == ST_MEM_RD || st == ST_MEM_WR) ? rdy : 1'($urandom);
        e.op  = (st == ST_DECODE || st == ST_MEM_ADDR) ? cur_op : 7'($urandom);
        e.ctrl = exp_ctrl(st, e.rdy);
        e.ret  = exp_ret;
        sb.push_back(e);
    endtask

    // Drain the scoreboard, one cycle per entry, checking mid-cycle
    task automatic run_queue(input string tag);
        cyc_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            mem_ready = e.rdy;
            opcode    = e.op;
            #1;
            n_vec++;
            if (state !== e.st) begin
                n_err++;
                $display("FAIL %s state: got %0d expected %0d", tag, state, e.st);
            end
            n_vec++;
            if (act_ctrl !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl in state %0d: got %b expected %b", tag, e.st, act_ctrl, e.ctrl);
            end
            n_vec++;
            if (retired !== e.ret) begin
                n_err++;
                $display("FAIL %s retired in state %0d: got %0d expected %0d", tag, e.st, retired, e.ret);
            end
        end
    endtask

    // One complete instruction with fw fetch waits and mw memory waits
    task automatic do_instr(input string tag, input logic [6:0] op, input int fw, input int mw);
        cur_op = op;
        for (int i = 0; i < fw; i++) push_cyc(ST_FETCH, 1'b0);
        push_cyc(ST_FETCH, 1'b1);
        push_cyc(ST_DECODE, 1'b0);
        case (op)
            OP_R: begin push_cyc(ST_EXEC_R, 1'b0); push_cyc(ST_WB_ALU, 1'b0); end
            OP_I: begin push_cyc(ST_EXEC_I, 1'b0); push_cyc(ST_WB_ALU, 1'b0); end
            OP_LW: begin
                push_cyc(ST_MEM_ADDR, 1'b0);
                for (int i = 0; i < mw; i++) push_cyc(ST_MEM_RD, 1'b0);
                push_cyc(ST_MEM_RD, 1'b1);
                push_cyc(ST_WB_MEM, 1'b0);
            end
            OP_SW: begin
                push_cyc(ST_MEM_ADDR, 1'b0);
                for (int i = 0; i < mw; i++) push_cyc(ST_MEM_WR, 1'b0);
                push_cyc(ST_MEM_WR, 1'b1);
            end
            default: push_cyc(ST_BRANCH, 1'b0);
        endcase
        run_queue(tag);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = OP_R;
        exp_ret   = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (state !== ST_IDLE || act_ctrl !== 16'h0 || retired !== 4'd0) begin
            n_err++;
            $display("FAIL reset_hold: got state=%0d ctrl=%b retired=%0d expected 0/0/0",
                     state, act_ctrl, retired);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (state !== ST_IDLE || act_ctrl !== 16'h0) begin
            n_err++;
            $display("FAIL reset_release_idle: got state=%0d ctrl=%b expected 0/0", state, act_ctrl);
        end
    endtask

    task automatic test_r_type();   do_instr("add", OP_R, 0, 0);  endtask
    task automatic test_i_type();   do_instr("addi", OP_I, 1, 0); endtask
    task automatic test_load();     do_instr("lw", OP_LW, 2, 3);  endtask
    task automatic test_store();    do_instr("sw", OP_SW, 0, 2);  endtask
    task automatic test_branch();   do_instr("beq", OP_BR, 0, 0); endtask

    task automatic test_back_to_back();
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BR;
        for (int i = 0; i < 8; i++) begin
            do_instr("b2b", ops[$urandom_range(0, 4)], int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_trap();
        cur_op = OP_BAD;
        push_cyc(ST_FETCH, 1'b1);
        push_cyc(ST_DECODE, 1'b0);
        for (int i = 0; i < 20; i++) push_cyc(ST_TRAP, 1'b0);
        run_queue("trap");
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (state !== ST_IDLE || illegal !== 1'b0 || retired !== 4'd0) begin
            n_err++;
            $display("FAIL trap_reset: got state=%0d illegal=%b retired=%0d expected 0/0/0",
                     state, illegal, retired);
        end
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = 4'd0;
    endtask

    task automatic test_reset_mid_write();
        do_instr("pre_r", OP_R, 0, 0);
        cur_op = OP_SW;
        push_cyc(ST_FETCH, 1'b1);
        push_cyc(ST_DECODE, 1'b0);
        push_cyc(ST_MEM_ADDR, 1'b0);
        push_cyc(ST_MEM_WR, 1'b0);
        push_cyc(ST_MEM_WR, 1'b0);
        run_queue("sw_abort");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_vec++;
        if (mem_write !== 1'b1 || state !== ST_MEM_WR) begin
            n_err++;
            $display("FAIL sw_hold: got mem_write=%b state=%0d expected 1/7", mem_write, state);
        end
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (mem_write !== 1'b0 || state !== ST_IDLE || retired !== 4'd0 || act_ctrl !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid_write: got mem_write=%b state=%0d retired=%0d ctrl=%b expected 0/0/0/0",
                     mem_write, state, retired, act_ctrl);
        end
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = 4'd0;
        @(posedge clk);
        #1;
        n_vec++;
        if (state !== ST_FETCH) begin
            n_err++;
            $display("FAIL first_fetch: got state=%0d expected 1", state);
        end
        // Resynchronise the scoreboard to the FETCH just entered
        cur_op = OP_R;
        push_cyc(ST_EXEC_R, 1'b0);
        sb.delete();
        @(negedge clk);
        mem_ready = 1'b1;
        opcode    = OP_R;
        cur_op    = OP_R;
        push_cyc(ST_DECODE, 1'b0);
        push_cyc(ST_EXEC_R, 1'b0);
        push_cyc(ST_WB_ALU, 1'b0);
        run_queue("post_reset_add");
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic test_wrap();
        // One already retired after reset; 15 more lands on 16 == 0 mod 16
        for (int i = 0; i < 15; i++) do_instr("wrap", OP_R, int'($urandom_range(0, 1)), 0);
        @(negedge clk);
        #1;
        n_vec++;
        if (retired !== 4'd0 || state !== ST_FETCH) begin
            n_err++;
            $display("FAIL counter_wrap: got retired=%0d state=%0d expected 0/1", retired, state);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_ret   = 4'd0;
        cur_op    = OP_R;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        test_reset();
        test_r_type();
        test_i_type();
        test_load();
        test_store();
        test_branch();
        test_back_to_back();
        test_trap();
        test_reset_mid_write();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
